// File: rtl/clk_div_sched.sv
// Programmable clock-enable divider with glitch-free config scheduling at period boundaries.
// Optional PERIOD_CNT counter is built only when CLK_DIV_SCHED_PERIOD_CNT_EN is defined.
module clk_div_sched #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [DIV_WIDTH-1:0] CFG_DIV,
  input  logic                 CFG_VALID,
  output logic                 CFG_READY,
  output logic                 CFG_ERR,
  output logic                 OUT_SIG,
  output logic                 OUT_TICK,
  output logic [DIV_WIDTH-1:0] ACTIVE_DIV,
  output logic [CNT_WIDTH-1:0] PERIOD_CNT
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0] active_div, div_nxt;
  logic [DIV_WIDTH-1:0] pend_div, pend_nxt;
  logic                 cfg_err, err_nxt;

  logic running;
  logic wrap;
  logic cfg_acc;
  logic cfg_ok;

  assign running = (state != IDLE);
  assign wrap    = running && (cnt == active_div - DIV_WIDTH'(1));
  assign cfg_acc = CFG_VALID && CFG_READY;
  assign cfg_ok  = cfg_acc && (CFG_DIV >= DIV_WIDTH'(2));

  // Ready drops combinationally with RST so nothing is accepted during reset.
  assign CFG_READY  = !RST && (state != PEND);
  assign CFG_ERR    = cfg_err;
  assign OUT_SIG    = running && (cnt <= (active_div >> 1));
  assign OUT_TICK   = running && (cnt == '0);
  assign ACTIVE_DIV = active_div;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      active_div <= DIV_WIDTH'(DEFAULT_DIV);
      pend_div   <= DIV_WIDTH'(DEFAULT_DIV);
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      active_div <= div_nxt;
      pend_div   <= pend_nxt;
      cfg_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = active_div;
    pend_nxt  = pend_div;
    err_nxt   = cfg_acc && !cfg_ok;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (cfg_ok) div_nxt = CFG_DIV;
        if (EN) state_nxt = RUN;
      end
      RUN: begin
        if (wrap) begin
          // A config accepted on the wrap edge takes effect for the new period directly.
          cnt_nxt   = '0;
          if (cfg_ok) div_nxt = CFG_DIV;
          state_nxt = EN ? RUN : IDLE;
        end else begin
          cnt_nxt = cnt + DIV_WIDTH'(1);
          if (cfg_ok) begin
            pend_nxt  = CFG_DIV;
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          cnt_nxt   = '0;
          div_nxt   = pend_div;
          state_nxt = EN ? RUN : IDLE;
        end else begin
          cnt_nxt = cnt + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
  logic [CNT_WIDTH-1:0] period_cnt;
  logic                 pc_clr;

  assign pc_clr     = (state == IDLE) && EN;
  assign PERIOD_CNT = period_cnt;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST || pc_clr) begin
      period_cnt <= '0;
    end else if (wrap && (period_cnt != '1)) begin
      period_cnt <= period_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign PERIOD_CNT = '0;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboarded bench for clk_div_sched: a behavioural model queues expected outputs per edge.
module tb_clk_div_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        CFG_VALID = 1'b0;
  logic [15:0] CFG_DIV = 16'd0;
  logic        CFG_READY, CFG_ERR, OUT_SIG, OUT_TICK;
  logic [15:0] ACTIVE_DIV;
  logic [31:0] PERIOD_CNT;

  clk_div_sched #(.DIV_WIDTH(16), .DEFAULT_DIV(15), .CNT_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CFG_DIV(CFG_DIV), .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY), .CFG_ERR(CFG_ERR), .OUT_SIG(OUT_SIG), .OUT_TICK(OUT_TICK),
    .ACTIVE_DIV(ACTIVE_DIV), .PERIOD_CNT(PERIOD_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        sig;
    logic        tick;
    logic        rdy;
    logic        err;
    logic [15:0] div;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: 0 = idle, 1 = run, 2 = pending.
  int     m_state, m_cnt, m_div, m_pend;
  logic   m_err;
  longint m_pc;
  logic   s_sig, s_tick;
  int     hi, tk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc, ok;
    if (RST) begin
      m_state = 0; m_cnt = 0; m_div = 15; m_pend = 15; m_err = 0; m_pc = 0;
    end else begin
      acc   = CFG_VALID && (m_state != 2);
      ok    = acc && (CFG_DIV >= 2);
      m_err = acc && !ok;
      if (m_state == 0) begin
        if (ok) m_div = CFG_DIV;
        if (EN) begin m_state = 1; m_pc = 0; end
      end else if (m_cnt == m_div - 1) begin
        m_cnt = 0;
        if (m_pc < 64'hFFFF_FFFF) m_pc++;
        if (m_state == 2) m_div = m_pend;
        else if (ok) m_div = CFG_DIV;
        m_state = EN ? 1 : 0;
      end else begin
        m_cnt++;
        if (ok) begin m_pend = CFG_DIV; m_state = 2; end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.sig  = (m_state != 0) && (m_cnt <= m_div / 2);
    e.tick = (m_state != 0) && (m_cnt == 0);
    e.rdy  = !RST && (m_state != 2);
    e.err  = m_err;
    e.div  = m_div[15:0];
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    e.pc   = m_pc[31:0];
`else
    e.pc   = 32'd0;
`endif
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("out_sig", OUT_SIG, e.sig);
    chk("out_tick", OUT_TICK, e.tick);
    chk("cfg_ready", CFG_READY, e.rdy);
    chk("cfg_err", CFG_ERR, e.err);
    chk("active_div", ACTIVE_DIV, e.div);
    chk("period_cnt", PERIOD_CNT, e.pc);
    s_sig  = OUT_SIG;
    s_tick = OUT_TICK;
  endtask

  task automatic wait_cnt(input int target);
    int k = 0;
    while ((m_state == 0 || m_cnt != target) && k < 64) begin
      step();
      k++;
    end
    if (k >= 64) chk("wait_cnt_timeout", k, 0);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (m_state != 0 && k < 64) begin
      step();
      k++;
    end
    if (k >= 64) chk("wait_idle_timeout", k, 0);
  endtask

  // Counts OUT_SIG/OUT_TICK over n consecutive samples, starting with the current one.
  task automatic measure(input int n);
    hi = 0;
    tk = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(s_sig);
      tk += int'(s_tick);
      step();
    end
  endtask

  initial begin
    int k;
    // Reset: outputs quiet and not ready while RST is held.
    step();
    step();
    chk("rst_ready_low", CFG_READY, 0);
    chk("rst_div_default", ACTIVE_DIV, 15);
    RST = 1'b0;
    step();

    // Illegal divider in IDLE is rejected with a single-cycle error pulse.
    CFG_VALID = 1'b1; CFG_DIV = 16'd1;
    step();
    CFG_VALID = 1'b0;
    chk("err_pulse", CFG_ERR, 1);
    step();
    chk("err_one_cycle", CFG_ERR, 0);
    chk("err_div_kept", ACTIVE_DIV, 15);

    // Free run at 15: tick every 15 cycles, high for cnt 0..7.
    EN = 1'b1;
    step();
    chk("first_run_tick", OUT_TICK, 1);
    measure(30);
    chk("div15_high", hi, 16);
    chk("div15_ticks", tk, 2);

    // Config 4 accepted at cnt=3 waits in PEND until the wrap.
    wait_cnt(3);
    CFG_VALID = 1'b1; CFG_DIV = 16'd4;
    step();
    CFG_VALID = 1'b0;
    chk("pend_ready_low", CFG_READY, 0);
    chk("pend_div_old", ACTIVE_DIV, 15);
    wait_cnt(0);
    chk("div4_applied", ACTIVE_DIV, 4);
    measure(4);
    chk("div4_high", hi, 3);
    chk("div4_ticks", tk, 1);

    // Move to 10, then drop EN mid-period: the period still completes.
    wait_cnt(1);
    CFG_VALID = 1'b1; CFG_DIV = 16'd10;
    step();
    CFG_VALID = 1'b0;
    wait_cnt(0);
    chk("div10_applied", ACTIVE_DIV, 10);
    wait_cnt(5);
    EN = 1'b0;
    wait_idle(k);
    chk("stop_latency", k, 5);
    chk("idle_sig_low", OUT_SIG, 0);

    // Reset while pending discards the pending value.
    EN = 1'b1;
    step();
    wait_cnt(2);
    CFG_VALID = 1'b1; CFG_DIV = 16'd12;
    step();
    CFG_VALID = 1'b0;
    wait_cnt(6);
    RST = 1'b1; EN = 1'b0;
    step();
    chk("rst_pend_div", ACTIVE_DIV, 15);
    chk("rst_pend_ready", CFG_READY, 0);
    chk("rst_pend_sig", OUT_SIG, 0);
    step();
    RST = 1'b0;
    step();
    EN = 1'b1;
    step();
    measure(15);
    chk("pend_lost_div", ACTIVE_DIV, 15);
    chk("pend_lost_ticks", tk, 1);

    // Config 2 accepted exactly on the wrap applies to the very next period.
    wait_cnt(14);
    CFG_VALID = 1'b1; CFG_DIV = 16'd2;
    step();
    CFG_VALID = 1'b0;
    chk("wrap_cfg_div", ACTIVE_DIV, 2);
    chk("wrap_cfg_ready", CFG_READY, 1);
    measure(4);
    chk("div2_high", hi, 4);
    chk("div2_ticks", tk, 2);
`ifndef CLK_DIV_SCHED_PERIOD_CNT_EN
    chk("period_cnt_tied", PERIOD_CNT, 0);
`endif

    EN = 1'b0;
    wait_idle(k);
    step();
    chk("final_idle_tick", OUT_TICK, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16: width of the divider value.
REQ-002 SHALL have parameter DEFAULT_DIV, default 15: divider loaded at reset; legal range 2..2^DIV_WIDTH-1.
REQ-003 SHALL have parameter CNT_WIDTH, default 32: width of the period counter.
REQ-004 SHALL have port CLK  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port EN  input  1: run request; start or stop of the divided output.
REQ-007 SHALL have port CFG_DIV  input  DIV_WIDTH: requested divider value.
REQ-008 SHALL have port CFG_VALID  input  1: CFG_DIV is valid.
REQ-009 SHALL have port CFG_READY  output  1: block can accept a config.
REQ-010 SHALL have port CFG_ERR  output  1: one-cycle pulse; an illegal config was rejected.
REQ-011 SHALL have port OUT_SIG  output  1: divided clock-enable waveform.
REQ-012 SHALL have port OUT_TICK  output  1: one-cycle pulse at each period start.
REQ-013 SHALL have port ACTIVE_DIV  output  DIV_WIDTH: divider currently in effect.
REQ-014 SHALL have port PERIOD_CNT  output  CNT_WIDTH: number of completed periods since the last start.

Function
REQ-015 SHALL implement states IDLE, RUN and PEND; PEND means RUN with a config waiting to be applied.
REQ-016 SHALL keep a phase counter cnt (DIV_WIDTH bits) that runs 0..ACTIVE_DIV-1 in RUN and PEND and is held at 0 in IDLE.
REQ-017 SHALL drive OUT_SIG = (state!=IDLE) && (cnt <= ACTIVE_DIV/2), using integer division; OUT_SIG is low in IDLE.
REQ-018 SHALL drive OUT_TICK = (state!=IDLE) && (cnt==0).
REQ-019 SHALL, in IDLE with EN=1, enter RUN on the next edge with cnt=0, so OUT_TICK is high in the first RUN cycle.
REQ-020 SHALL, in RUN or PEND at cnt==ACTIVE_DIV-1 (the wrap), set cnt to 0 and increment PERIOD_CNT, which saturates at all-ones.
REQ-021 SHALL sample EN only at the wrap in RUN or PEND: if EN=0 there, go to IDLE. The current period always completes.
REQ-022 SHALL drive CFG_READY high in IDLE and RUN, and low in PEND and during reset.
REQ-023 SHALL accept a config on CFG_VALID && CFG_READY; CFG_DIV < 2 SHALL be rejected: CFG_ERR pulses on the next cycle and nothing changes.
REQ-024 SHALL load an accepted legal config in IDLE into ACTIVE_DIV on the accepting edge.
REQ-025 SHALL latch an accepted legal config in RUN and enter PEND; at the next wrap, ACTIVE_DIV takes the pending value and the new period uses it.
REQ-026 SHALL, when an accept in RUN coincides with the wrap, apply the value at that wrap and remain in RUN.
REQ-027 SHALL, at a wrap with a config pending and EN=0, apply the config and go to IDLE.
REQ-028 SHALL clear PERIOD_CNT on each IDLE to RUN transition.

Reset
REQ-029 SHALL, while RST=1 at an edge, set state=IDLE, cnt=0, ACTIVE_DIV=DEFAULT_DIV, PERIOD_CNT=0, CFG_ERR=0, and discard any pending config.
REQ-030 SHALL therefore hold OUT_SIG=0, OUT_TICK=0 and CFG_READY=0 while RST=1; a reset mid-period aborts the period with no final tick.

Configuration
REQ-031 SHALL implement PERIOD_CNT and its increment logic only when macro CLK_DIV_SCHED_PERIOD_CNT_EN is defined.
REQ-032 SHALL tie PERIOD_CNT to 0 when CLK_DIV_SCHED_PERIOD_CNT_EN is not defined; all other behaviour is unchanged.

Verification
REQ-033 SHALL cover: reset release, EN=1, DEFAULT_DIV=15 -> OUT_TICK every 15 cycles, OUT_SIG high 8 cycles (cnt 0..7) and low 7 cycles.
REQ-034 SHALL cover: config of 4 while running at 15, accepted at cnt=3 -> CFG_READY low until the wrap, then a period of 4 (OUT_SIG high 3, low 1).
REQ-035 SHALL cover: CFG_DIV=1 with CFG_VALID in IDLE -> CFG_ERR pulses 1 cycle and ACTIVE_DIV stays 15.
REQ-036 SHALL cover: EN dropped at cnt=5, div 10 -> output continues to cnt=9, then IDLE with OUT_SIG=0; PERIOD_CNT holds the completed count (macro defined).
REQ-037 SHALL cover: RST asserted at cnt=6 in PEND -> next cycle IDLE, ACTIVE_DIV=15, pending value lost, CFG_READY=0 while RST=1.
REQ-038 SHALL cover: config of 2 accepted exactly at the wrap -> the next cycle starts a period of 2 (OUT_SIG high 2, low 0); macro undefined -> PERIOD_CNT always 0.
